aes_128_arbiter: RTL and testbench

AES_128_ARBITER -- requirements
Module: aes_128_arbiter

---
 rtl/aes_128_pkg.sv | 16 +
 rtl/aes_128_rr_arb.sv | 48 ++++
 rtl/aes_128_arbiter.sv | 140 ++++++++++++++
 tb/tb_aes_128_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_pkg.sv
// aes_128_pkg: shared types and constants for the aes_128 arbiter slice
//   AES_BLK_W   - AES block and key width in bits
//   AES_LATENCY - default core latency, core_start to valid core_out
//   arb_state_e - arbiter FSM states
package aes_128_pkg;

    localparam int AES_BLK_W   = 128;
    localparam int AES_LATENCY = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/aes_128_rr_arb.sv
// aes_128_rr_arb: N_REQ-wide round-robin arbiter, pointer moves past each grant
//   clk, rst    - clock, asynchronous active-high reset
//   en_i        - arbitration allowed this cycle; grants and pointer updates only when high
//   req_i       - request vector
//   grant_o     - one-hot grant (all-zero when disabled or nothing requested)
//   grant_idx_o - index of the winner (valid when grant_o is non-zero)
module aes_128_rr_arb #(
    parameter  int N_REQ = 2,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IW-1:0]    grant_idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] win;
    logic          found;
    int            c;

    // Scan from the pointer upwards, wrapping, and take the first requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        c     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            c = (int'(ptr_q) + i) % N_REQ;
            if (!found && req_i[IW'(c)]) begin
                found = 1'b1;
                win   = IW'(c);
            end
        end
    end

    assign grant_o     = (en_i && found) ? (N_REQ'(1) << win) : '0;
    assign grant_idx_o = win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= '0;
        else if (en_i && found)
            ptr_q <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end

endmodule

// File: rtl/aes_128_arbiter.sv
// aes_128_arbiter: shares one external aes_128 core among N_REQ requesters
//   clk, rst             - clock, asynchronous active-high reset
//   req_valid/req_ready  - per-requester handshake; ready is one-hot, only in IDLE
//   req_data/req_key     - per-requester plaintext and key
//   rsp_valid/rsp_ready  - result handshake
//   rsp_data/rsp_id      - ciphertext and owning requester index
//   core_start           - one-cycle start pulse to the core
//   core_in/core_key     - operands held steady for the whole operation
//   core_out             - core ciphertext, sampled LATENCY cycles after core_start
//   busy                 - high whenever the FSM is not IDLE
//   blk_cnt              - completed response count (only with AES_ARB_BLK_CNT_EN)
module aes_128_arbiter
    import aes_128_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int LATENCY = AES_LATENCY
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_valid,
    output logic [N_REQ-1:0]                  req_ready,
    input  logic [N_REQ-1:0][AES_BLK_W-1:0]   req_data,
    input  logic [N_REQ-1:0][AES_BLK_W-1:0]   req_key,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [AES_BLK_W-1:0]              rsp_data,
    output logic [$clog2(N_REQ)-1:0]          rsp_id,
    output logic                              core_start,
    output logic [AES_BLK_W-1:0]              core_in,
    output logic [AES_BLK_W-1:0]              core_key,
    input  logic [AES_BLK_W-1:0]              core_out,
    output logic                              busy
`ifdef AES_ARB_BLK_CNT_EN
    ,
    output logic [15:0]                       blk_cnt
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LATENCY + 1);

    arb_state_e           state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        id_q;
    logic [IW-1:0]        grant_idx;
    logic [AES_BLK_W-1:0] core_in_q;
    logic [AES_BLK_W-1:0] core_key_q;
    logic [AES_BLK_W-1:0] rsp_data_q;
    logic                 core_start_q;
    logic                 rsp_valid_q;
    logic                 arb_en;
    logic                 hs;

    // Grants are masked during reset so req_ready reads all-zero while rst is high.
    assign arb_en = (state_q == ST_IDLE) && !rst;
    assign hs     = |req_ready;

    aes_128_rr_arb #(
        .N_REQ (N_REQ)
    ) u_rr_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (arb_en),
        .req_i       (req_valid),
        .grant_o     (req_ready),
        .grant_idx_o (grant_idx)
    );

    // Counter is loaded with LATENCY on the grant, so it reaches zero exactly in
    // the cycle core_out becomes valid (LATENCY cycles after the start pulse).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            id_q         <= '0;
            core_in_q    <= '0;
            core_key_q   <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        state_q      <= ST_RUN;
                        cnt_q        <= CW'(LATENCY);
                        id_q         <= grant_idx;
                        core_in_q    <= req_data[grant_idx];
                        core_key_q   <= req_key[grant_idx];
                        core_start_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= core_out;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_start = core_start_q;
    assign core_in    = core_in_q;
    assign core_key   = core_key_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = id_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef AES_ARB_BLK_CNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            blk_cnt_q <= '0;
        else if (state_q == ST_DONE && rsp_ready)
            blk_cnt_q <= blk_cnt_q + 16'd1;
    end

    assign blk_cnt = blk_cnt_q;
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_ready_idle:   assert property (@(posedge clk) disable iff (rst) busy |-> req_ready == '0);
    a_rsp_hold:     assert property (@(posedge clk) disable iff (rst)
                        rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_data) && $stable(rsp_id));

endmodule

// File: tb/tb_aes_128_arbiter.sv
// tb_aes_128_arbiter: randomized self-checking bench with an AES-128 core model and a transaction-level reference
module tb_aes_128_arbiter;

    localparam int N  = 2;
    localparam int L  = 10;
    localparam int IW = $clog2(N);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req_valid = '0;
    logic [N-1:0]        req_ready;
    logic [N-1:0][127:0] req_data = '0;
    logic [N-1:0][127:0] req_key = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [127:0]        rsp_data;
    logic [IW-1:0]       rsp_id;
    logic                core_start;
    logic [127:0]        core_in;
    logic [127:0]        core_key;
    logic [127:0]        core_out = '0;
    logic                busy;
`ifdef AES_ARB_BLK_CNT_EN
    logic [15:0]         blk_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: age 0 idle, 1..L+1 operation running, L+2 result offered
    int           m_last = N - 1;
    int           m_age  = 0;
    int           m_id   = 0;
    int           m_blk  = 0;
    logic [127:0] m_data = '0;
    logic [127:0] m_key  = '0;
    logic [127:0] m_res  = '0;
    int           rsp_ids[$];

    logic [7:0]   sbox[256];

    aes_128_arbiter #(
        .N_REQ   (N),
        .LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_key    (req_key),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .core_start (core_start),
        .core_in    (core_in),
        .core_key   (core_key),
        .core_out   (core_out),
        .busy       (busy)
`ifdef AES_ARB_BLK_CNT_EN
        ,
        .blk_cnt    (blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   rk[176];
        logic [7:0]   w[4];
        logic [7:0]   a[4];
        logic [7:0]   rc = 8'h01;
        logic [7:0]   tb;
        logic [127:0] out;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            s[i]  = pt[127-8*i -: 8];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) w[j] = rk[i-4+j];
            if (i % 16 == 0) begin
                tb   = w[0];
                w[0] = sbox[w[1]] ^ rc;
                w[1] = sbox[w[2]];
                w[2] = sbox[w[3]];
                w[3] = sbox[tb];
                rc   = xt(rc);
            end
            for (int j = 0; j < 4; j++) rk[i+j] = rk[i-16+j] ^ w[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int i = 0; i < 16; i++) s[i] = t[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    s[4*c]   = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
                    s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r+i];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] t;
        for (int i = 1; i <= N; i++) begin
            t = v >> ((last + i) % N);
            if (t[0]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic rand_reqs();
        for (int j = 0; j < N; j++) begin
            req_data[j] = rnd128();
            req_key[j]  = rnd128();
        end
    endtask

    // Core model: result valid exactly in the LATENCY-th cycle after the start pulse, garbage otherwise.
    initial begin
        int           k;
        logic [127:0] res;
        k   = 0;
        res = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                k   = L + 1;
                res = aes(core_in, core_key);
            end else if (k > 0) begin
                k--;
            end
            core_out = (k == 1) ? res : rnd128();
        end
    end

    // One cycle: inputs were set at the negedge; compare against the reference, then advance it.
    task automatic step();
        int w;
        logic [IW-1:0] wi;
        #1;
        if (rst) begin
            check("rst_req_ready", 128'(req_ready), 0);
            check("rst_rsp_valid", 128'(rsp_valid), 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_rsp_id", 128'(rsp_id), 0);
            check("rst_core_start", 128'(core_start), 0);
            check("rst_core_in", core_in, 0);
            check("rst_core_key", core_key, 0);
            check("rst_busy", 128'(busy), 0);
`ifdef AES_ARB_BLK_CNT_EN
            check("rst_blk_cnt", 128'(blk_cnt), 0);
`endif
            m_age  = 0;
            m_last = N - 1;
            m_blk  = 0;
        end else begin
            w = (m_age == 0) ? rr_pick(req_valid, m_last) : -1;
            check("req_ready", 128'(req_ready), (w < 0) ? 128'(0) : (128'(1) << w));
            check("busy", 128'(busy), 128'(m_age != 0));
            check("core_start", 128'(core_start), 128'(m_age == 1));
            check("rsp_valid", 128'(rsp_valid), 128'(m_age == L + 2));
            if (m_age >= 1 && m_age <= L + 1) begin
                check("core_in", core_in, m_data);
                check("core_key", core_key, m_key);
            end
            if (m_age == L + 2) begin
                check("rsp_data", rsp_data, m_res);
                check("rsp_id", 128'(rsp_id), 128'(m_id));
            end
`ifdef AES_ARB_BLK_CNT_EN
            check("blk_cnt", 128'(blk_cnt), 128'(16'(m_blk)));
`endif
            if (w >= 0) begin
                wi     = w[IW-1:0];
                m_last = w;
                m_id   = w;
                m_data = req_data[wi];
                m_key  = req_key[wi];
                m_res  = aes(m_data, m_key);
                m_age  = 1;
            end else if (m_age > 0 && m_age < L + 2) begin
                m_age++;
            end else if (m_age == L + 2 && rsp_ready) begin
                m_age = 0;
                m_blk++;
                rsp_ids.push_back(int'(rsp_id));
            end
        end
        @(negedge clk);
    endtask

    // n = cycle offset from the handshake cycle at which rsp_valid is first seen (bounded)
    task automatic wait_rsp(output int n);
        n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int           n;
        logic [127:0] exp;
        build_sbox();
        @(negedge clk);
        req_valid = 2'b11;
        step();
        step();
        rst       = 1'b0;
        req_valid = '0;
        step();

        // known-answer block on requester 0
        req_valid   = 2'b01;
        req_data[0] = 128'h00112233445566778899aabbccddeeff;
        req_key[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        rsp_ready   = 1'b1;
        step();
        req_valid = '0;
        wait_rsp(n);
        check("kat_latency", 128'(n), 128'(L + 2));
        check("kat_data", rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("kat_id", 128'(rsp_id), 0);
        step();

        // both requesters held valid: grants alternate starting at 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ids.delete();
        req_valid = 2'b11;
        repeat (4 * (L + 3)) begin
            rand_reqs();
            step();
        end
        check("alt_count", 128'(rsp_ids.size()), 4);
        for (int i = 0; i < rsp_ids.size(); i++) check("alt_id", 128'(rsp_ids[i]), 128'(i % 2));

        // result held while consumer stalls, no grant meanwhile
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        rand_reqs();
        step();
        exp       = m_res;
        req_valid = 2'b11;
        wait_rsp(n);
        check("hold_latency", 128'(n), 128'(L + 2));
        repeat (5) begin
            step();
            check("hold_valid", 128'(rsp_valid), 1);
            check("hold_data", rsp_data, exp);
            check("hold_ready", 128'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        step();

        // request inputs churn during the operation
        req_valid = 2'b10;
        rand_reqs();
        exp = aes(req_data[1], req_key[1]);
        step();
        n = 1;
        while (!rsp_valid && n < 40) begin
            rand_reqs();
            req_valid = N'($urandom);
            step();
            n++;
        end
        check("churn_data", rsp_data, exp);
        check("churn_id", 128'(rsp_id), 1);
        req_valid = '0;
        step();

        // reset mid-operation at T+5
        req_valid = 2'b10;
        step();
        req_valid = '0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (20) begin
            step();
            check("abort_no_rsp", 128'(rsp_valid), 0);
        end
        req_valid = 2'b11;
        #1;
        check("abort_prio", 128'(req_ready), 128'(2'b01));
        step();
        req_valid = '0;
        wait_rsp(n);
        step();

`ifdef AES_ARB_BLK_CNT_EN
        rst = 1'b1;
        step();
        rst       = 1'b0;
        req_valid = 2'b01;
        repeat (3 * (L + 3)) begin
            rand_reqs();
            step();
        end
        check("blk_cnt3", 128'(blk_cnt), 3);
        req_valid = '0;
`endif

        // random traffic with occasional resets
        repeat (400) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            rand_reqs();
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
